// File: rtl/joy_pad_pkg.sv
// joy_pad_pkg: shared indices and encodings for the Megadrive pad emulator
package joy_pad_pkg;
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_B = 4;
    localparam int BTN_C = 5;
    localparam int BTN_A = 6;
    localparam int BTN_S = 7;
    localparam int BTN_Z = 8;
    localparam int BTN_Y = 9;
    localparam int BTN_X = 10;
    localparam int BTN_M = 11;
    localparam int PIN_U = 0;
    localparam int PIN_D = 1;
    localparam int PIN_L = 2;
    localparam int PIN_R = 3;
    localparam int PIN_P6 = 4;
    localparam int PIN_P9 = 5;
    localparam int PAD_PINS = 6;
    localparam int P1_BASE = 4;
    localparam int P2_BASE = 12;
    localparam logic [2:0] CNT_IDLE = 3'd0;
    localparam logic [2:0] CNT_RESTART = 3'd1;
    localparam logic [2:0] CNT_SIX = 3'd3;
    localparam logic [2:0] CNT_EXT = 3'd4;
endpackage

// File: rtl/megadrive_pad_model.sv
// megadrive_pad_model: one virtual Sega pad; JOYENC_SIX_BUTTON_EN enables the 6-button counter and timeout
module megadrive_pad_model
    import joy_pad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel,
    input  logic [11:0] btn,
    output logic [5:0]  pins,
    output logic [2:0]  cnt
);
`ifdef JOYENC_SIX_BUTTON_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYCLES);
    logic          sel_prev;
    logic          sel_fall;
    logic [TW-1:0] idle;
    assign sel_fall = sel_prev & ~sel;
    // idle saturates so a long-parked pad keeps cnt at 0 without wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_prev <= 1'b1;
            idle     <= '0;
            cnt      <= CNT_IDLE;
        end else begin
            sel_prev <= sel;
            if (sel_fall) begin
                cnt  <= (cnt == CNT_EXT) ? CNT_RESTART : cnt + 3'd1;
                idle <= '0;
            end else if (idle == T_END)
                cnt <= CNT_IDLE;
            else
                idle <= idle + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= CNT_IDLE;
        else
            cnt <= CNT_IDLE;
    end
`endif
    assign pins[PIN_P9:PIN_P6] = sel ? {btn[BTN_C], btn[BTN_B]} : {btn[BTN_S], btn[BTN_A]};
    assign pins[PIN_R:PIN_U] = sel
        ? ((cnt == CNT_SIX) ? {btn[BTN_M], btn[BTN_X], btn[BTN_Y], btn[BTN_Z]}
                            : {btn[BTN_R], btn[BTN_L], btn[BTN_D], btn[BTN_U]})
        : (cnt == CNT_SIX) ? 4'b0000
        : (cnt == CNT_EXT) ? 4'b1111
        : {2'b00, btn[BTN_D], btn[BTN_U]};
endmodule

// File: rtl/joy_pad_emulator.sv
// joy_pad_emulator: two virtual Megadrive pads behind an emulated PISO shifter; JOYENC_SIX_BUTTON_EN selects 6-button pads
module joy_pad_emulator
    import joy_pad_pkg::*;
#(
    parameter int FRAME_LEN = 18,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] btn1_i,
    input  logic [11:0] btn2_i,
    input  logic        sel_i,
    input  logic        joy_clk_i,
    input  logic        joy_load_n_i,
    output logic        joy_data_o,
    output logic [2:0]  pad1_cnt_o,
    output logic [2:0]  pad2_cnt_o
);
    localparam int PW = $clog2(FRAME_LEN + 1);
    localparam logic [PW-1:0] POS_END = PW'(FRAME_LEN);
    logic [1:0]           sel_q;
    logic [1:0]           load_q;
    logic [2:0]           jclk_q;
    logic                 sel_s;
    logic                 load_s;
    logic                 jclk_rise;
    logic [5:0]           p1_pins;
    logic [5:0]           p2_pins;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] frame_next;
    logic [PW-1:0]        pos;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q  <= '1;
            load_q <= '1;
            jclk_q <= '0;
        end else begin
            sel_q  <= {sel_q[0], sel_i};
            load_q <= {load_q[0], joy_load_n_i};
            jclk_q <= {jclk_q[1:0], joy_clk_i};
        end
    end
    assign sel_s     = sel_q[1];
    assign load_s    = load_q[1];
    assign jclk_rise = jclk_q[1] & ~jclk_q[2];
    megadrive_pad_model #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_pad1 (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (sel_s),
        .btn     (btn1_i),
        .pins    (p1_pins),
        .cnt     (pad1_cnt_o)
    );
    megadrive_pad_model #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_pad2 (
        .clk     (clk),
        .reset_n (reset_n),
        .sel     (sel_s),
        .btn     (btn2_i),
        .pins    (p2_pins),
        .cnt     (pad2_cnt_o)
    );
    // first position of each pad field carries p9, the last carries U
    always_comb begin
        frame_next = '1;
        for (int i = 0; i < PAD_PINS; i++) begin
            frame_next[P1_BASE + i] = p1_pins[PIN_P9 - i];
            frame_next[P2_BASE + i] = p2_pins[PIN_P9 - i];
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame      <= '1;
            pos        <= '0;
            joy_data_o <= 1'b1;
        end else begin
            if (!load_s) begin
                frame <= frame_next;
                pos   <= '0;
            end else if (jclk_rise && pos != POS_END)
                pos <= pos + 1'b1;
            joy_data_o <= (pos < POS_END) ? frame[pos] : 1'b1;
        end
    end
endmodule

// File: tb/tb_joy_pad_emulator.sv
// tb_joy_pad_emulator: directed checks of pad multiplexing and the serial frame
module tb_joy_pad_emulator;
`ifdef JOYENC_SIX_BUTTON_EN
    localparam bit SIX = 1'b1;
`else
    localparam bit SIX = 1'b0;
`endif
    localparam int TIMEOUT = 24000;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] btn1_i = 12'hFFF;
    logic [11:0] btn2_i = 12'hFFF;
    logic        sel_i = 1'b1;
    logic        joy_clk_i = 1'b0;
    logic        joy_load_n_i = 1'b1;
    logic        joy_data_o;
    logic [2:0]  pad1_cnt_o;
    logic [2:0]  pad2_cnt_o;
    logic [17:0] f;
    int          checks = 0;
    int          errors = 0;
    joy_pad_emulator #(.FRAME_LEN(18), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn1_i       (btn1_i),
        .btn2_i       (btn2_i),
        .sel_i        (sel_i),
        .joy_clk_i    (joy_clk_i),
        .joy_load_n_i (joy_load_n_i),
        .joy_data_o   (joy_data_o),
        .pad1_cnt_o   (pad1_cnt_o),
        .pad2_cnt_o   (pad2_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic shift();
        joy_clk_i = 1'b1;
        tick(4);
        joy_clk_i = 1'b0;
        tick(4);
    endtask
    task automatic pulse_sel();
        sel_i = 1'b0;
        tick(6);
        sel_i = 1'b1;
        tick(6);
    endtask
    // a joy_clk pulse during load must not advance the position
    task automatic load_frame();
        joy_load_n_i = 1'b0;
        tick(4);
        shift();
        joy_load_n_i = 1'b1;
        tick(4);
    endtask
    task automatic read_frame(output logic [17:0] r);
        load_frame();
        for (int i = 0; i < 18; i++) begin
            r[i] = joy_data_o;
            shift();
        end
    endtask
    initial begin
        tick(3);
        check("rst_data", 18'(joy_data_o), 18'd1);
        check("rst_cnt1", 18'(pad1_cnt_o), 18'd0);
        reset_n = 1'b1;
        tick(4);
        read_frame(f);
        check("idle_frame", f, 18'h3FFFF);
        check("past_end", 18'(joy_data_o), 18'd1);
        check("idle_cnt2", 18'(pad2_cnt_o), 18'd0);
        btn1_i = 12'hFFE;
        btn2_i = 12'hFDF;
        read_frame(f);
        check("up_c", f, 18'h3EDFF);
        btn1_i = 12'hFFF;
        btn2_i = 12'hFFF;
        repeat (3) pulse_sel();
        btn1_i = 12'h7FB;
        read_frame(f);
        check("cnt3_high", f, SIX ? 18'h3FFBF : 18'h3FF7F);
        check("cnt3_val", 18'(pad1_cnt_o), SIX ? 18'd3 : 18'd0);
        sel_i = 1'b0;
        tick(6);
        btn1_i = 12'hF7F;
        read_frame(f);
        check("cnt4_low", f, SIX ? 18'h3FFEF : 18'h33F2F);
        check("cnt4_val", 18'(pad1_cnt_o), SIX ? 18'd4 : 18'd0);
        sel_i = 1'b1;
        tick(6);
        sel_i = 1'b0;
        tick(6);
        btn1_i = 12'hFBD;
        read_frame(f);
        check("cnt1_low", f, 18'h33E1F);
        check("cnt1_val", 18'(pad1_cnt_o), SIX ? 18'd1 : 18'd0);
        sel_i = 1'b1;
        tick(6);
        pulse_sel();
        check("cnt2_val", 18'(pad2_cnt_o), SIX ? 18'd2 : 18'd0);
        tick(TIMEOUT - 100);
        check("pre_timeout", 18'(pad1_cnt_o), SIX ? 18'd2 : 18'd0);
        tick(200);
        check("timeout1", 18'(pad1_cnt_o), 18'd0);
        check("timeout2", 18'(pad2_cnt_o), 18'd0);
        pulse_sel();
        btn1_i = 12'h7FE;
        read_frame(f);
        check("post_timeout", f, 18'h3FDFF);
        check("post_cnt", 18'(pad1_cnt_o), SIX ? 18'd1 : 18'd0);
        pulse_sel();
        sel_i = 1'b0;
        tick(6);
        btn1_i = 12'hFFF;
        read_frame(f);
        check("cnt3_low", f, SIX ? 18'h03C3F : 18'h33F3F);
        sel_i = 1'b1;
        tick(6);
        pulse_sel();
        btn1_i = 12'hFEF;
        load_frame();
        repeat (7) shift();
        btn1_i = 12'hFFD;
        btn2_i = 12'hFEF;
        read_frame(f);
        check("reload", f, 18'h3DEFF);
        btn1_i = 12'hFEF;
        btn2_i = 12'hFFF;
        load_frame();
        repeat (5) shift();
        check("pre_reset", 18'(joy_data_o), 18'd0);
        reset_n = 1'b0;
        #1;
        check("async_reset", 18'(joy_data_o), 18'd1);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("reset_cnt", 18'(pad1_cnt_o), 18'd0);
        shift();
        check("after_reset", 18'(joy_data_o), 18'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
